decode_4_10_scan: RTL and testbench
===================================

// Module: decode_4_10_scan
// PURPOSE
//  Reverse of the one-hot digit encoder: drives a multiplexed one-hot decimal display
//  (10 cathode lines, DIGITS anode lines) from a packed word of 4-bit digit codes.
//  - Scans the digits in time, one anode per slot, with a dead-time gap between slots.
//  - Accepts new words via valid/ready.
//  - Flags codes that are neither 0-9 nor the blank code.
//  - Sits between the digit-value datapath and the display pin drivers.
// PARAMETERS
//  DIGITS  4     number of display positions; >=1
//  DWELL   1000  cycles per slot with the anode on; >=1
//  BLANK   2     dead-time cycles per slot, anode and cathode off; >=0
// PORTS
//  i_clk      in   1         clock
//  i_rst      in   1         synchronous reset, active-high
//  i_digits   in   4*DIGITS  digit codes; [3:0] is digit 0 (rightmost, anode[0])
//  i_valid    in   1         i_digits is valid
//  o_ready    out  1         pending register is free; transfer happens on i_valid & o_ready
//  o_cathode  out  10        one-hot cathode, bit n = decimal n; 0 = dark
//  o_anode    out  DIGITS    one-hot anode of the lit position; 0 during dead time
//  o_unknown  out  1         the lit digit holds an illegal code (4'hA..4'hE)
// BEHAVIOUR
//  - Clock and reset: single clock i_clk. i_rst is synchronous.
//  - Reset values: o_cathode=0, o_anode=0, o_unknown=0, o_ready=1.
//    Reset also sets the active register to all 4'hF (blank) and empties the pending register.
//    Reset mid-frame takes effect on the next edge and the frame restarts at digit 0.
//  - All outputs are registered.
//  - Scan timing:
//    - Slot k = BLANK dead cycles, then DWELL lit cycles.
//    - Frame = DIGITS*(BLANK+DWELL) cycles; slots run k=0..DIGITS-1 and then wrap to 0.
//    - Slot 0 of the first frame starts on the first edge with i_rst low.
//  - FSM: S_DEAD -> S_LIT after BLANK cycles (straight to S_LIT when BLANK=0).
//    - S_LIT -> S_DEAD after DWELL cycles, incrementing the slot index modulo DIGITS.
//    - One down-counter serves both states.
//  - Outputs in S_DEAD: o_anode=0, o_cathode=0, o_unknown=0.
//  - Outputs in S_LIT: o_anode=1<<k. Cathode and flag decode from the active digit k:
//    - 0-9 gives o_cathode=1<<code and o_unknown=0.
//    - 4'hF (blank) gives o_cathode=0 and o_unknown=0.
//    - 4'hA..4'hE gives o_cathode=0 and o_unknown=1.
//  - Handshake:
//    - i_valid & o_ready writes the pending register; o_ready drops on the next cycle.
//    - On the last lit cycle of slot DIGITS-1: if pending is full, active<=pending,
//      pending is cleared, and o_ready=1 from the next cycle.
//    - A handshake in that same cycle while pending was empty loads pending only;
//      the word displays one frame later.
//    - The active register never changes mid-frame, so a frame never shows mixed words.
//  - i_digits is sampled only on a handshake. i_valid may stay high across cycles.
// CONFIGURATION
//  DECODE_LEADING_ZERO_BLANK_EN
//   - Defined: leading zeros are suppressed, reading from digit DIGITS-1 down.
//     - A 4'h0 digit with only 0 or 4'hF digits above it is shown as blank.
//     - Digit 0 is always shown.
//     - Suppressed digits give o_cathode=0 and o_unknown=0; anode timing is unchanged.
//   - Undefined: every 4'h0 digit lights cathode bit 0.
// TESTING  (DIGITS=4, DWELL=3, BLANK=1: slot=4 cycles, frame=16)
//  1 Reset, no load:
//    - All outputs are 0 and o_ready=1 during reset.
//    - After release, o_anode steps 0000, 0001x3, 0000, 0010x3, ... ;
//      o_cathode stays 0 and o_unknown stays 0.
//  2 Load 16'h9301 in frame 0. From frame 1:
//    - digit0 cathode=10'b0000000010
//    - digit1 cathode=10'b0000000001
//    - digit2 cathode=10'b0000001000
//    - digit3 cathode=10'b1000000000
//  3 Load 16'hFFA5:
//    - digit0 lights bit 5.
//    - digit1 has o_cathode=0 and o_unknown=1 for exactly its 3 lit cycles.
//    - digits 2 and 3 are dark with o_unknown=0.
//  4 Back-pressure, two words in one frame:
//    - The 1st word is accepted and o_ready=0.
//    - The 2nd word is held with i_valid=1 until o_ready rises after the frame's last lit cycle.
//    - The 2nd word is accepted next and displays one frame after the 1st.
//  5 Reset mid-frame: assert i_rst at frame cycle 7 with pending full.
//    - On the next edge all outputs are 0 and o_ready=1.
//    - The display then shows blanks; the pending word is lost.
//  6 Load 16'h0042:
//    - With DECODE_LEADING_ZERO_BLANK_EN: digits 3 and 2 are dark.
//    - Without it: digits 3 and 2 light bit 0.
//    - In both builds digit1=bit4 and digit0=bit2.

Source files
------------

// File: rtl/decode_4_10_scan.sv
// decode_4_10_scan: time-multiplexed one-hot decimal display driver with valid/ready word loading.
// Optional DECODE_LEADING_ZERO_BLANK_EN suppresses leading zeros from digit DIGITS-1 down.
module decode_4_10_scan #(
    parameter int DIGITS = 4,
    parameter int DWELL  = 1000,
    parameter int BLANK  = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [4*DIGITS-1:0]   i_digits,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [9:0]            o_cathode,
    output logic [DIGITS-1:0]     o_anode,
    output logic                  o_unknown
);
    localparam int CW = $clog2(DWELL + BLANK + 1);
    localparam int SW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    typedef enum logic [1:0] {S_IDLE, S_DEAD, S_LIT} state_t;
    state_t              state, nxt_state;
    logic [CW-1:0]       cnt, nxt_cnt;
    logic [SW-1:0]       slot, nxt_slot;
    logic [4*DIGITS-1:0] active, pend, nxt_active;
    logic [DIGITS-1:0]   sup;
    logic [3:0]          code;
    logic                hs, frame_end, wrap, blank, lit;
    // Outputs are registered from the next-cycle state so they line up with the slot being entered.
    always_comb begin
        hs = i_valid & o_ready;
        frame_end = state == S_LIT && cnt == '0 && slot == SW'(DIGITS - 1);
        nxt_active = frame_end && !o_ready ? pend : active;
        wrap = state == S_IDLE || (state == S_LIT && cnt == '0);
        nxt_slot = state == S_IDLE || (wrap && slot == SW'(DIGITS - 1)) ? '0 : wrap ? slot + 1'b1 : slot;
        nxt_state = wrap ? (BLANK > 0 ? S_DEAD : S_LIT) : (state == S_DEAD && cnt == '0) ? S_LIT : state;
        nxt_cnt = wrap ? (BLANK > 0 ? CW'(BLANK - 1) : CW'(DWELL - 1))
                : (state == S_DEAD && cnt == '0) ? CW'(DWELL - 1) : cnt - 1'b1;
        sup = '0;
`ifdef DECODE_LEADING_ZERO_BLANK_EN
        begin
            logic above;
            above = 1'b1;
            for (int i = DIGITS - 1; i > 0; i--) begin
                sup[i] = above && nxt_active[4*i +: 4] == 4'h0;
                above = above && (nxt_active[4*i +: 4] == 4'h0 || nxt_active[4*i +: 4] == 4'hF);
            end
        end
`endif
        code = 4'hF;
        blank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (SW'(i) == nxt_slot) begin
                code = nxt_active[4*i +: 4];
                blank = sup[i];
            end
        end
        lit = nxt_state == S_LIT;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            slot      <= '0;
            active    <= '1;
            o_ready   <= 1'b1;
            o_anode   <= '0;
            o_cathode <= '0;
            o_unknown <= 1'b0;
        end else begin
            state     <= nxt_state;
            cnt       <= nxt_cnt;
            slot      <= nxt_slot;
            active    <= nxt_active;
            o_ready   <= hs ? 1'b0 : frame_end ? 1'b1 : o_ready;
            o_anode   <= lit ? DIGITS'(1) << nxt_slot : '0;
            o_cathode <= lit && !blank && code <= 4'd9 ? 10'(1) << code : '0;
            o_unknown <= lit && code >= 4'hA && code <= 4'hE;
        end
        // Pending is only meaningful while o_ready is low, so it needs no reset.
        if (hs) pend <= i_digits;
    end
endmodule

// File: tb/tb_decode_4_10_scan.sv
// tb_decode_4_10_scan: table vectors, directed corner sequences and random traffic
// against a frame-position reference model (DIGITS=4, DWELL=3, BLANK=1).
module tb_decode_4_10_scan;
    logic        clk = 1'b0;
    logic        rst, valid, ready, unknown;
    logic [15:0] digits;
    logic [9:0]  cathode;
    logic [3:0]  anode;

    always #5 clk = ~clk;

    decode_4_10_scan #(.DIGITS(4), .DWELL(3), .BLANK(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_digits(digits), .i_valid(valid),
        .o_ready(ready), .o_cathode(cathode), .o_anode(anode), .o_unknown(unknown)
    );

    int          vectors = 0, miscompares = 0;
    int          m_t = -1, m_accepts = 0, n0;
    logic [15:0] m_active = '1, m_pend = '0;
    bit          m_full = 0;

    typedef struct {
        logic        r;
        logic        v;
        logic [15:0] d;
        logic [3:0]  an;
        logic [9:0]  cat;
        logic        unk;
        logic        rdy;
    } vec_t;
    vec_t        tbl[18];
    logic [3:0]  an_seq[18] = '{0, 0, 1, 1, 1, 0, 2, 2, 2, 0, 4, 4, 4, 0, 8, 8, 8, 0};

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0d: got %h, expected %h", name, m_t, got, exp);
        end
    endtask

    // Expected {ready, unknown, anode, cathode} from the position inside the 16-cycle frame.
    function automatic logic [15:0] model_out();
        int pos, slot;
        bit lit, sup;
        logic [3:0] code;
        logic [9:0] cat;
        if (m_t < 0) return 16'h8000;
        pos  = m_t % 16;
        slot = pos / 4;
        lit  = (pos % 4) != 0;
        code = m_active[slot*4 +: 4];
        sup  = 0;
`ifdef DECODE_LEADING_ZERO_BLANK_EN
        sup = slot > 0 && code == 0;
        for (int j = slot + 1; j < 4; j++)
            if (m_active[j*4 +: 4] != 4'h0 && m_active[j*4 +: 4] != 4'hF) sup = 0;
`endif
        cat = (lit && code <= 9 && !sup) ? 10'b1 << code : 10'b0;
        return {!m_full, lit && code >= 10 && code <= 14, lit ? 4'b1 << slot : 4'b0, cat};
    endfunction

    task automatic cyc(input logic r, input logic v, input logic [15:0] d, input bit check_it);
        bit hs, fe;
        rst = r; valid = v; digits = d;
        if (r) begin
            m_t = -1; m_active = '1; m_full = 0;
        end else begin
            hs = v && !m_full;
            fe = m_t >= 0 && m_t % 16 == 15;
            if (fe && m_full) begin m_active = m_pend; m_full = 0; end
            if (hs) begin m_pend = d; m_full = 1; m_accepts++; end
            m_t++;
        end
        @(posedge clk);
        @(negedge clk);
        if (check_it) chk("model", {ready, unknown, anode, cathode}, model_out());
    endtask

    task automatic run_to(input int p);
        for (int i = 0; i < 40; i++) begin
            cyc(0, 0, 16'h0, 1);
            if (m_t >= 0 && m_t % 16 == p) return;
        end
        chk("run_to_timeout", 16'(m_t % 16), 16'(p));
    endtask

    initial begin
        rst = 1; valid = 0; digits = 0;
        tbl[0] = '{1, 0, 16'h0, 4'b0, 10'b0, 0, 1};
        for (int i = 1; i < 18; i++) tbl[i] = '{0, 0, 16'h0, an_seq[i], 10'b0, 0, 1};

        // 1: reset and an empty scan
        for (int i = 0; i < 18; i++) begin
            cyc(tbl[i].r, tbl[i].v, tbl[i].d, 1);
            chk("table", {ready, unknown, anode, cathode}, {tbl[i].rdy, tbl[i].unk, tbl[i].an, tbl[i].cat});
        end

        // 2: 9301
        cyc(0, 1, 16'h9301, 1);
        chk("t2_ready_drop", 16'(ready), 16'd0);
        run_to(15);
        run_to(2);  chk("t2_digit0", 16'(cathode), 16'b0000000010);
        run_to(6);  chk("t2_digit1", 16'(cathode), 16'b0000000001);
        run_to(10); chk("t2_digit2", 16'(cathode), 16'b0000001000);
        run_to(14); chk("t2_digit3", 16'(cathode), 16'b1000000000);

        // 3: FFA5 with an illegal code
        run_to(1);
        cyc(0, 1, 16'hFFA5, 1);
        run_to(15);
        run_to(2);  chk("t3_digit0", 16'(cathode), 16'b0000100000);
        for (int p = 5; p < 8; p++) begin
            run_to(p); chk("t3_unknown_lit", {unknown, cathode}, {1'b1, 10'b0});
        end
        run_to(8);  chk("t3_unknown_dead", 16'(unknown), 16'd0);
        run_to(10); chk("t3_digit2_dark", {unknown, cathode}, 16'd0);
        run_to(14); chk("t3_digit3_dark", {unknown, cathode}, 16'd0);

        // 4: back-pressure, second word held until ready rises
        run_to(4);
        cyc(0, 1, 16'h1234, 1);
        chk("t4_ready_drop", 16'(ready), 16'd0);
        n0 = m_accepts;
        for (int i = 0; i < 40 && m_accepts == n0; i++) cyc(0, 1, 16'h8765, 1);
        chk("t4_second_accepted", 16'(m_accepts - n0), 16'd1);
        chk("t4_ready_after_second", 16'(ready), 16'd0);
        run_to(2);  chk("t4_first_word", 16'(cathode), 16'b0000010000);
        run_to(15);
        run_to(2);  chk("t4_second_word", 16'(cathode), 16'b0000100000);

        // 5: reset mid-frame with pending full
        run_to(1);
        cyc(0, 1, 16'h5678, 1);
        chk("t5_pending_full", 16'(ready), 16'd0);
        run_to(7);
        cyc(1, 0, 16'h0, 1);
        chk("t5_reset_outputs", {ready, unknown, anode, cathode}, 16'h8000);
        run_to(2);  chk("t5_blank_digit0", {anode, cathode}, {4'b0001, 10'b0});
        run_to(15);
        run_to(2);  chk("t5_pending_lost", {anode, cathode}, {4'b0001, 10'b0});

        // 6: leading zeros
        run_to(1);
        cyc(0, 1, 16'h0042, 1);
        run_to(15);
        run_to(2);  chk("t6_digit0", 16'(cathode), 16'b0000000100);
        run_to(6);  chk("t6_digit1", 16'(cathode), 16'b0000010000);
`ifdef DECODE_LEADING_ZERO_BLANK_EN
        run_to(10); chk("t6_digit2", 16'(cathode), 16'b0);
        run_to(14); chk("t6_digit3", 16'(cathode), 16'b0);
`else
        run_to(10); chk("t6_digit2", 16'(cathode), 16'b1);
        run_to(14); chk("t6_digit3", 16'(cathode), 16'b1);
`endif

        // random traffic with occasional resets
        for (int i = 0; i < 1500; i++)
            cyc($urandom_range(0, 199) == 0, 1'($urandom_range(0, 1)), 16'($urandom), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
